ad_chn_sched: RTL and testbench

AD_CHN_SCHED -- requirements
Module: ad_chn_sched

---
 rtl/ad_chn_sched_pkg.sv | 18 +
 rtl/ad_chn_sched_pick.sv | 25 ++
 rtl/ad_chn_sched.sv | 127 ++++++++++++
 tb/tb_ad_chn_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_chn_sched_pkg.sv
// Shared globals for the AD channel scheduler: widths, channel count and FSM state encodings.
package ad_chn_sched_pkg;

  localparam int unsigned AD_CHN_NUM       = 8;
  localparam int unsigned AD_CHN_NBIT      = 3;
  localparam int unsigned AD_DATA_NBIT     = 16;
  localparam int unsigned BUFFER_ADDR_NBIT = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NEXT   = 3'd1,
    ST_SWITCH = 3'd2,
    ST_READ   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_EOP    = 3'd5
  } sched_state_t;

endpackage

// File: rtl/ad_chn_sched_pick.sv
// ad_chn_pick: combinational lowest-pending-channel selector (enabled and not yet served).
module ad_chn_pick
  import ad_chn_sched_pkg::*;
(
  input  logic [AD_CHN_NUM-1:0]  mask,
  input  logic [AD_CHN_NUM-1:0]  served,
  output logic [AD_CHN_NBIT-1:0] chn,
  output logic                   none
);

  logic [AD_CHN_NUM-1:0] pending;

  always_comb begin
    pending = mask & ~served;
    chn     = '0;
    none    = 1'b1;
    for (int unsigned i = 0; i < AD_CHN_NUM; i++) begin
      if (pending[i] && none) begin
        chn  = AD_CHN_NBIT'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ad_chn_sched.sv
// ad_chn_sched: scans enabled AD channels, copies WORDS_PER_CH words each into the TX buffer.
// Define AD_SCHED_AUTO_EN for continuous rescan until start is pulsed again.
module ad_chn_sched
  import ad_chn_sched_pkg::*;
#(
  parameter int unsigned WORDS_PER_CH = 256,
  parameter int unsigned ADDR_NBIT    = BUFFER_ADDR_NBIT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [AD_CHN_NUM-1:0]   ch_mask,
  output logic                    busy,
  output logic                    done,
  output logic [AD_CHN_NBIT-1:0]  ad_chn,
  output logic                    ad_switch,
  output logic                    ad_rd,
  input  logic [AD_DATA_NBIT-1:0] ad_data,
  input  logic                    tx_ready,
  output logic                    tx_vd,
  output logic [ADDR_NBIT-1:0]    tx_addr,
  output logic [AD_DATA_NBIT-1:0] tx_data,
  output logic                    tx_eop
);

  localparam int unsigned WBITS = (WORDS_PER_CH > 1) ? $clog2(WORDS_PER_CH) : 1;

  sched_state_t           state, state_nxt;
  logic [AD_CHN_NUM-1:0]  mask_q, served_q;
  logic [AD_CHN_NBIT-1:0] slot_q, pick_chn;
  logic [WBITS-1:0]       word_q;
  logic                   pick_none;
`ifdef AD_SCHED_AUTO_EN
  logic                   stop_q;
`endif

  ad_chn_pick u_pick (
    .mask   (mask_q),
    .served (served_q),
    .chn    (pick_chn),
    .none   (pick_none)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    ad_switch = 1'b0;
    ad_rd     = 1'b0;
    tx_eop    = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_NEXT;
      ST_NEXT:   state_nxt = pick_none ? ST_EOP : ST_SWITCH;
      ST_SWITCH: begin
        ad_switch = 1'b1;
        state_nxt = ST_READ;
      end
      ST_READ: begin
        ad_rd = tx_ready;
        if (tx_ready && (word_q == WBITS'(WORDS_PER_CH - 1))) state_nxt = ST_DRAIN;
      end
      ST_DRAIN:  state_nxt = ST_NEXT;
      ST_EOP: begin
        done   = 1'b1;
        // An empty mask produces no frame, so no end-of-packet either.
        tx_eop = (served_q != '0);
`ifdef AD_SCHED_AUTO_EN
        state_nxt = (stop_q || start) ? ST_IDLE : ST_NEXT;
`else
        state_nxt = ST_IDLE;
`endif
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q   <= '0;
      served_q <= '0;
      slot_q   <= '0;
      word_q   <= '0;
      ad_chn   <= '0;
      tx_vd    <= 1'b0;
      tx_addr  <= '0;
`ifdef AD_SCHED_AUTO_EN
      stop_q   <= 1'b0;
`endif
    end else begin
      tx_vd <= ad_rd;
      if (ad_rd) begin
        tx_addr <= ADDR_NBIT'({slot_q, word_q});
        word_q  <= word_q + 1'b1;
      end
      case (state)
        ST_IDLE: if (start) begin
          mask_q   <= ch_mask;
          served_q <= '0;
          slot_q   <= '0;
        end
        ST_NEXT: if (!pick_none) begin
          ad_chn             <= pick_chn;
          served_q[pick_chn] <= 1'b1;
          word_q             <= '0;
        end
        ST_DRAIN: slot_q <= slot_q + 1'b1;
        ST_EOP: begin
          served_q <= '0;
          slot_q   <= '0;
        end
        default: ;
      endcase
`ifdef AD_SCHED_AUTO_EN
      if (state == ST_IDLE || state == ST_EOP) stop_q <= 1'b0;
      else if (start)                          stop_q <= 1'b1;
`endif
    end
  end

  assign tx_data = tx_vd ? ad_data : '0;

endmodule

// File: tb/tb_ad_chn_sched.sv
// Self-checking bench for ad_chn_sched: vector table, corner sequences and random scans vs a stream model.
module tb_ad_chn_sched;

  localparam int unsigned W  = 4;
  localparam int unsigned AN = 11;
`ifdef AD_SCHED_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, tx_ready;
  logic [7:0]    ch_mask;
  logic [15:0]   ad_data;
  logic          busy, done, ad_switch, ad_rd, tx_vd, tx_eop;
  logic [2:0]    ad_chn;
  logic [AN-1:0] tx_addr;
  logic [15:0]   tx_data;

  always #5 clk = ~clk;

  ad_chn_sched #(.WORDS_PER_CH(W), .ADDR_NBIT(AN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask),
    .busy(busy), .done(done), .ad_chn(ad_chn), .ad_switch(ad_switch),
    .ad_rd(ad_rd), .ad_data(ad_data), .tx_ready(tx_ready), .tx_vd(tx_vd),
    .tx_addr(tx_addr), .tx_data(tx_data), .tx_eop(tx_eop)
  );

  int n_checks = 0, n_fail = 0;
  int cnt_sw, cnt_vd, cnt_eop, cnt_done, rd_idx;
  int exp_ch_q[$];
  logic [AN-1:0] exp_addr_q[$];
  logic [15:0]   exp_data_q[$];

  typedef struct {
    logic [7:0] mask;
    int lat, nsw, nvd, neop;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cache_word(input int ch, input int w);
    return {3'(ch), 5'b10110, 8'(w)};
  endfunction

  // Expected write stream: enabled channels ascending, packed into consecutive slots.
  task automatic model_scan(input logic [7:0] mask);
    int slot = 0;
    for (int ch = 0; ch < 8; ch++) begin
      if (mask[ch]) begin
        exp_ch_q.push_back(ch);
        for (int w = 0; w < W; w++) begin
          exp_addr_q.push_back(AN'(slot * W + w));
          exp_data_q.push_back(cache_word(ch, w));
        end
        slot++;
      end
    end
  endtask

  task automatic clear_model();
    exp_ch_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    cnt_sw = 0; cnt_vd = 0; cnt_eop = 0; cnt_done = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_switch"}, ad_switch, 0);
    check({tag, "_rd"}, ad_rd, 0);
    check({tag, "_vd"}, tx_vd, 0);
    check({tag, "_eop"}, tx_eop, 0);
    check({tag, "_chn"}, ad_chn, 0);
    check({tag, "_addr"}, tx_addr, 0);
    check({tag, "_data"}, tx_data, 0);
  endtask

  // One clock: monitor outputs at negedge, then answer cache reads after the next posedge.
  task automatic tick();
    logic p_rd, p_sw;
    logic [2:0] p_chn;
    @(negedge clk);
    check("rd_during_stall", ad_rd & ~tx_ready, 0);
    check("eop_without_done", tx_eop & ~done, 0);
    if (ad_switch) begin
      cnt_sw++;
      check("switch_expected", exp_ch_q.size() != 0, 1);
      if (exp_ch_q.size() != 0) check("switch_chn", ad_chn, exp_ch_q.pop_front());
    end
    if (tx_vd) begin
      cnt_vd++;
      check("vd_expected", exp_addr_q.size() != 0, 1);
      if (exp_addr_q.size() != 0) begin
        check("tx_addr", tx_addr, exp_addr_q.pop_front());
        check("tx_data", tx_data, exp_data_q.pop_front());
      end
    end
    if (tx_eop) cnt_eop++;
    if (done) begin
      cnt_done++;
      check("done_stream_drained", exp_addr_q.size(), 0);
    end
    p_rd = ad_rd; p_sw = ad_switch; p_chn = ad_chn;
    @(posedge clk); #1;
    if (p_sw) rd_idx = 0;
    if (p_rd) begin
      ad_data = cache_word(int'(p_chn), rd_idx);
      rd_idx++;
    end else begin
      ad_data = 16'($urandom);
    end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic run_scan(input logic [7:0] mask, input int mode, input int restart_at,
                          output int lat);
    clear_model();
    model_scan(mask);
    lat      = -1;
    ch_mask  = mask;
    start    = 1'b1;
    tx_ready = ready_for(mode, 0);
    tick();
    for (int c = 1; c < 1500; c++) begin
      start    = (c == restart_at) || (AUTO && restart_at < 0 && c == 1);
      if (start) ch_mask = 8'hFF;
      tx_ready = ready_for(mode, c);
      tick();
      if (cnt_done != 0 && lat < 0) lat = c;
      if (lat >= 0 && c >= lat + 4) break;
    end
    start = 1'b0; tx_ready = 1'b1;
    check("scan_finished", lat >= 0, 1);
    check("done_count", cnt_done, 1);
    check("busy_after_scan", busy, 0);
    check("stream_left", exp_addr_q.size() + exp_ch_q.size(), 0);
  endtask

  initial begin
    int lat;
    logic [7:0] m;
    rst_n = 1'b0; start = 1'b0; tx_ready = 1'b1; ch_mask = '0; ad_data = '0; rd_idx = 0;
    clear_model();
    vecs[0] = '{mask: 8'h05, lat: 16, nsw: 2, nvd: 8,  neop: 1};
    vecs[1] = '{mask: 8'h00, lat: 2,  nsw: 0, nvd: 0,  neop: 0};
    vecs[2] = '{mask: 8'h80, lat: 9,  nsw: 1, nvd: 4,  neop: 1};
    vecs[3] = '{mask: 8'hFF, lat: 58, nsw: 8, nvd: 32, neop: 1};
    vecs[4] = '{mask: 8'h3C, lat: 30, nsw: 4, nvd: 16, neop: 1};
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_scan(vecs[i].mask, 0, -1, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_switches", i), cnt_sw, vecs[i].nsw);
      check($sformatf("v%0d_writes", i), cnt_vd, vecs[i].nvd);
      check($sformatf("v%0d_eop", i), cnt_eop, vecs[i].neop);
    end

    run_scan(8'h80, 1, -1, lat);
    check("toggle_writes", cnt_vd, W);

    run_scan(8'h06, 0, 5, lat);
    check("restart_ignored_latency", lat, 16);
    check("restart_ignored_writes", cnt_vd, 2 * W);

    // Reset pulse in the middle of a channel read.
    clear_model();
    model_scan(8'h11);
    ch_mask = 8'h11; start = 1'b1; tx_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("midscan_reset");
    clear_model();
    rd_idx = 0;
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("post_reset_eop", cnt_eop, 0);
    check("post_reset_done", cnt_done, 0);
    check("post_reset_busy", busy, 0);
    run_scan(8'h10, 0, -1, lat);
    check("post_reset_latency", lat, 9);

    for (int i = 0; i < 6; i++) begin
      m = 8'($urandom);
      run_scan(m, 2, -1, lat);
      check("rand_switches", cnt_sw, $countones(m));
      check("rand_writes", cnt_vd, $countones(m) * W);
      check("rand_eop", cnt_eop, (m != 0) ? 1 : 0);
    end

`ifdef AD_SCHED_AUTO_EN
    clear_model();
    repeat (3) model_scan(8'h01);
    ch_mask = 8'h01; start = 1'b1; tx_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 300; c++) begin
      start = 1'b0;
      if (cnt_done == 2 && !busy) break;
      tick();
      if (cnt_done == 2 && done) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      if (cnt_done == 3) begin
        repeat (4) tick();
        break;
      end
    end
    check("auto_frames", cnt_done, 3);
    check("auto_eops", cnt_eop, 3);
    check("auto_stopped", busy, 0);
    check("auto_stream_left", exp_addr_q.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
